// File: rtl/rv_decode_stage.sv
// RV decode stage: register file, same-cycle WB bypass, load-use bubble and the ID/EX register.
// Define RV_DECODE_ILLEGAL_EN to flag unsupported opcodes and out-of-range register indices.
module rv_decode_stage #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int PC_W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_id_valid,
    input  logic [31:0]     if_id_ir,
    input  logic [PC_W-1:0] if_id_pc,
    output logic            id_ready,
    input  logic            ex_ready,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_ex_valid,
    output logic [31:0]     id_ex_ir,
    output logic [PC_W-1:0] id_ex_pc,
    output logic [4:0]      id_ex_rd,
    output logic [XLEN-1:0] id_ex_rs1_val,
    output logic [XLEN-1:0] id_ex_rs2_val,
    output logic [XLEN-1:0] id_ex_imm,
    output logic [2:0]      id_ex_funct3,
    output logic [6:0]      id_ex_funct7,
    output logic            id_ex_illegal
);
    localparam int AW = $clog2(REG_COUNT);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    function automatic logic in_range(input logic [4:0] idx);
        return ({27'd0, idx} < 32'(REG_COUNT));
    endfunction

    logic [XLEN-1:0] rf_q [REG_COUNT];

    logic            valid_q, valid_d;
    logic [31:0]     ir_q, ir_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] imm_q, imm_d;

    logic [6:0]      opc;
    logic [4:0]      rs1_idx, rs2_idx, load_rd;
    logic            rs1_used, rs2_used;
    logic            hazard, adv;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [31:0]     imm32;

    assign opc     = if_id_ir[6:0];
    assign rs1_idx = if_id_ir[19:15];
    assign rs2_idx = if_id_ir[24:20];
    assign load_rd = ir_q[11:7];

    always_comb begin
        rs1_used = !(opc inside {OP_LUI, OP_AUIPC, OP_JAL});
        rs2_used = opc inside {OP_OP, OP_STORE, OP_BRANCH};
    end

    assign hazard   = if_id_valid && valid_q && (ir_q[6:0] == OP_LOAD) && (load_rd != 5'd0)
                      && ((rs1_used && (rs1_idx == load_rd)) || (rs2_used && (rs2_idx == load_rd)));
    assign adv      = ex_ready || !valid_q;
    assign id_ready = adv && !hazard;

    // Write-back data is forwarded so a same-cycle write is visible to the reader.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1_idx != 5'd0 && in_range(rs1_idx)) begin
            rs1_val = (wb_we && wb_rd == rs1_idx) ? wb_data : rf_q[rs1_idx[AW-1:0]];
        end
        if (rs2_idx != 5'd0 && in_range(rs2_idx)) begin
            rs2_val = (wb_we && wb_rd == rs2_idx) ? wb_data : rf_q[rs2_idx[AW-1:0]];
        end
    end

    always_comb begin
        imm32 = '0;
        case (opc)
            OP_LOAD, OP_IMM, OP_JALR, OP_MISC, OP_SYSTEM:
                imm32 = {{20{if_id_ir[31]}}, if_id_ir[31:20]};
            OP_STORE:
                imm32 = {{20{if_id_ir[31]}}, if_id_ir[31:25], if_id_ir[11:7]};
            OP_BRANCH:
                imm32 = {{20{if_id_ir[31]}}, if_id_ir[7], if_id_ir[30:25], if_id_ir[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {if_id_ir[31:12], 12'b0};
            OP_JAL:
                imm32 = {{12{if_id_ir[31]}}, if_id_ir[19:12], if_id_ir[20], if_id_ir[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        if (adv) begin
            valid_d = if_id_valid && !flush && !hazard;
            if (valid_d) begin
                ir_d  = if_id_ir;
                pc_d  = if_id_pc;
                rs1_d = rs1_val;
                rs2_d = rs2_val;
                imm_d = XLEN'($signed(imm32));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ir_q    <= '0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            if (wb_we && wb_rd != 5'd0 && in_range(wb_rd)) begin
                rf_q[wb_rd[AW-1:0]] <= wb_data;
            end
        end
    end

`ifdef RV_DECODE_ILLEGAL_EN
    logic illegal_q, illegal_dec, rd_used;

    always_comb begin
        rd_used     = !(opc inside {OP_STORE, OP_BRANCH});
        illegal_dec = !(opc inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                                    OP_STORE, OP_IMM, OP_OP, OP_MISC, OP_SYSTEM})
                      || (if_id_ir[1:0] != 2'b11)
                      || (rd_used && !in_range(if_id_ir[11:7]))
                      || (rs1_used && !in_range(rs1_idx))
                      || (rs2_used && !in_range(rs2_idx));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (adv) begin
            illegal_q <= valid_d && illegal_dec;
        end
    end

    assign id_ex_illegal = illegal_q;
`else
    assign id_ex_illegal = 1'b0;
`endif

    assign id_ex_valid   = valid_q;
    assign id_ex_ir      = ir_q;
    assign id_ex_pc      = pc_q;
    assign id_ex_rd      = ir_q[11:7];
    assign id_ex_rs1_val = rs1_q;
    assign id_ex_rs2_val = rs2_q;
    assign id_ex_imm     = imm_q;
    assign id_ex_funct3  = ir_q[14:12];
    assign id_ex_funct7  = ir_q[31:25];

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: RV32I instance against a behavioural model, RV64E instance with directed cases.
module tb_rv_decode_stage;
`ifdef RV_DECODE_ILLEGAL_EN
    localparam bit ILL_ON = 1'b1;
`else
    localparam bit ILL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        if_id_valid, id_ready, ex_ready, flush, wb_we;
    logic [31:0] if_id_ir, if_id_pc, wb_data;
    logic [4:0]  wb_rd;
    logic        id_ex_valid, id_ex_illegal;
    logic [31:0] id_ex_ir, id_ex_pc, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm;
    logic [4:0]  id_ex_rd;
    logic [2:0]  id_ex_funct3;
    logic [6:0]  id_ex_funct7;

    logic        b_if_id_valid, b_id_ready, b_ex_ready, b_flush, b_wb_we;
    logic [31:0] b_if_id_ir, b_if_id_pc;
    logic [63:0] b_wb_data;
    logic [4:0]  b_wb_rd;
    logic        b_id_ex_valid, b_id_ex_illegal;
    logic [31:0] b_id_ex_ir, b_id_ex_pc;
    logic [63:0] b_id_ex_rs1_val, b_id_ex_rs2_val, b_id_ex_imm;
    logic [4:0]  b_id_ex_rd;
    logic [2:0]  b_id_ex_funct3;
    logic [6:0]  b_id_ex_funct7;

    rv_decode_stage #(.XLEN(32), .REG_COUNT(32), .PC_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .if_id_valid(if_id_valid), .if_id_ir(if_id_ir), .if_id_pc(if_id_pc),
        .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_ex_valid(id_ex_valid), .id_ex_ir(id_ex_ir), .id_ex_pc(id_ex_pc), .id_ex_rd(id_ex_rd),
        .id_ex_rs1_val(id_ex_rs1_val), .id_ex_rs2_val(id_ex_rs2_val), .id_ex_imm(id_ex_imm),
        .id_ex_funct3(id_ex_funct3), .id_ex_funct7(id_ex_funct7), .id_ex_illegal(id_ex_illegal)
    );

    rv_decode_stage #(.XLEN(64), .REG_COUNT(16), .PC_W(32)) u_dut_e64 (
        .clk(clk), .rst(rst),
        .if_id_valid(b_if_id_valid), .if_id_ir(b_if_id_ir), .if_id_pc(b_if_id_pc),
        .id_ready(b_id_ready), .ex_ready(b_ex_ready), .flush(b_flush),
        .wb_we(b_wb_we), .wb_rd(b_wb_rd), .wb_data(b_wb_data),
        .id_ex_valid(b_id_ex_valid), .id_ex_ir(b_id_ex_ir), .id_ex_pc(b_id_ex_pc), .id_ex_rd(b_id_ex_rd),
        .id_ex_rs1_val(b_id_ex_rs1_val), .id_ex_rs2_val(b_id_ex_rs2_val), .id_ex_imm(b_id_ex_imm),
        .id_ex_funct3(b_id_ex_funct3), .id_ex_funct7(b_id_ex_funct7), .id_ex_illegal(b_id_ex_illegal)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model state for the RV32I instance
    logic [31:0] m_rf [32];
    logic        m_valid, m_ill;
    logic [31:0] m_ir, m_pc, m_rs1, m_rs2, m_imm;
    bit          exp_ready, exp_adv;
    logic        obs_ready;

    function automatic bit uses_rs1(input logic [6:0] op);
        return !(op inside {7'h37, 7'h17, 7'h6F});
    endfunction

    function automatic bit uses_rs2(input logic [6:0] op);
        return op inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic bit known_op(input logic [6:0] op);
        return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    endfunction

    // Immediate value as a weighted sum of instruction fields, sign bit subtracted.
    function automatic logic [31:0] ref_imm(input logic [31:0] ir);
        logic [31:0] s;
        logic [31:0] r;
        s = ir[31] ? 32'd1 : 32'd0;
        r = '0;
        case (ir[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73:
                r = 32'(ir[31:20]) - s * 32'd4096;
            7'h23:
                r = 32'(ir[31:25]) * 32'd32 + 32'(ir[11:7]) - s * 32'd4096;
            7'h63:
                r = 32'(ir[11:8]) * 32'd2 + 32'(ir[30:25]) * 32'd32 + 32'(ir[7]) * 32'd2048 - s * 32'd4096;
            7'h37, 7'h17:
                r = 32'(ir[31:12]) * 32'd4096;
            7'h6F:
                r = 32'(ir[30:21]) * 32'd2 + 32'(ir[20]) * 32'd2048 + 32'(ir[19:12]) * 32'd4096
                    - s * 32'd1048576;
            default:
                r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx, input logic we, input logic [4:0] rd,
                                           input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
        if (we && rd == idx) return wd;
        return m_rf[idx];
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [6:0]  ops [13];
        logic [31:0] ir;
        ops = '{7'h03, 7'h13, 7'h33, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73, 7'h0F, 7'h0B, 7'h0C};
        ir = $urandom;
        ir[6:0]   = ops[$urandom_range(0, 12)];
        ir[11:7]  = 5'($urandom_range(0, 7));
        ir[19:15] = 5'($urandom_range(0, 7));
        ir[24:20] = 5'($urandom_range(0, 7));
        return ir;
    endfunction

    task automatic check_outputs();
        check("valid", id_ex_valid, m_valid);
        check("illegal", id_ex_illegal, m_ill);
        if (m_valid) begin
            check("ir", id_ex_ir, m_ir);
            check("pc", id_ex_pc, m_pc);
            check("rd", id_ex_rd, m_ir[11:7]);
            check("rs1_val", id_ex_rs1_val, m_rs1);
            check("rs2_val", id_ex_rs2_val, m_rs2);
            check("imm", id_ex_imm, m_imm);
            check("funct3", id_ex_funct3, m_ir[14:12]);
            check("funct7", id_ex_funct7, m_ir[31:25]);
        end
    endtask

    // Drives one cycle on the RV32I instance starting at a falling edge and ends at the next one.
    task automatic step(input logic v, input logic [31:0] ir, input logic [31:0] pc, input logic er,
                        input logic fl, input logic we, input logic [4:0] rd, input logic [31:0] wd);
        bit          hz, nv, nill;
        logic [31:0] n_rs1, n_rs2, n_imm;
        if_id_valid = v;  if_id_ir = ir;  if_id_pc = pc;
        ex_ready    = er; flush    = fl;  wb_we    = we; wb_rd = rd; wb_data = wd;
        #1;
        hz = v && m_valid && (m_ir[6:0] == 7'h03) && (m_ir[11:7] != 5'd0)
             && ((uses_rs1(ir[6:0]) && ir[19:15] == m_ir[11:7])
                 || (uses_rs2(ir[6:0]) && ir[24:20] == m_ir[11:7]));
        exp_adv   = er || !m_valid;
        exp_ready = exp_adv && !hz;
        obs_ready = id_ready;
        check("id_ready", id_ready, exp_ready);
        nv    = v && !fl && !hz;
        nill  = nv && ILL_ON && (!known_op(ir[6:0]) || ir[1:0] != 2'b11);
        n_rs1 = m_read(ir[19:15], we, rd, wd);
        n_rs2 = m_read(ir[24:20], we, rd, wd);
        n_imm = ref_imm(ir);
        @(posedge clk);
        if (exp_adv) begin
            m_valid = nv;
            m_ill   = nill;
            if (nv) begin
                m_ir = ir; m_pc = pc; m_rs1 = n_rs1; m_rs2 = n_rs2; m_imm = n_imm;
            end
        end
        if (we && rd != 5'd0) m_rf[rd] = wd;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic bstep(input logic [31:0] ir, input logic we, input logic [4:0] rd, input logic [63:0] wd);
        b_if_id_valid = 1'b1; b_if_id_ir = ir; b_if_id_pc = 32'h2000;
        b_ex_ready    = 1'b1; b_flush    = 1'b0;
        b_wb_we       = we;   b_wb_rd    = rd; b_wb_data = wd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic randomize_inputs();
        if_id_valid = 1'($urandom); if_id_ir = $urandom; if_id_pc = $urandom;
        ex_ready = 1'($urandom); flush = 1'($urandom);
        wb_we = 1'($urandom); wb_rd = 5'($urandom); wb_data = $urandom;
        b_if_id_valid = 1'($urandom); b_if_id_ir = $urandom; b_if_id_pc = $urandom;
        b_ex_ready = 1'($urandom); b_flush = 1'($urandom);
        b_wb_we = 1'($urandom); b_wb_rd = 5'($urandom); b_wb_data = {$urandom, $urandom};
    endtask

    initial begin
        logic        cur_v, cur_fl, er, we;
        logic [31:0] cur_ir, cur_pc, wd;
        logic [4:0]  rd;

        rst = 1'b1;
        randomize_inputs();
        @(posedge clk);
        @(negedge clk);
        randomize_inputs();
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", id_ex_valid, 1'b0);
        check("rst_payload", |{id_ex_ir, id_ex_pc, id_ex_rd, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm,
                               id_ex_funct3, id_ex_funct7, id_ex_illegal}, 1'b0);
        check("rst_e64_valid", b_id_ex_valid, 1'b0);
        check("rst_e64_payload", |{b_id_ex_ir, b_id_ex_pc, b_id_ex_rd, b_id_ex_rs1_val, b_id_ex_rs2_val,
                                   b_id_ex_imm, b_id_ex_funct3, b_id_ex_funct7, b_id_ex_illegal}, 1'b0);

        rst = 1'b0;
        m_valid = 1'b0; m_ill = 1'b0;
        m_ir = '0; m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        if_id_valid = 1'b0; ex_ready = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;

        // RV64E instance: directed cases (RV32I instance idles with no writes meanwhile)
        bstep(32'h00028313, 1'b0, 5'd0, 64'd0);
        check("e64_cleared_x5", b_id_ex_rs1_val, 64'd0);
        bstep(32'h00000013, 1'b1, 5'd20, 64'hDEAD);
        bstep(32'h000A0313, 1'b0, 5'd0, 64'd0);
        check("e64_x20_reads0", b_id_ex_rs1_val, 64'd0);
        check("e64_x20_illegal", b_id_ex_illegal, ILL_ON);
        bstep(32'h00028313, 1'b1, 5'd5, 64'h1122334455667788);
        check("e64_bypass", b_id_ex_rs1_val, 64'h1122334455667788);
        bstep(32'h00028313, 1'b0, 5'd0, 64'd0);
        check("e64_rf_x5", b_id_ex_rs1_val, 64'h1122334455667788);
        bstep(32'h800002B7, 1'b0, 5'd0, 64'd0);
        check("e64_lui_imm", b_id_ex_imm, 64'hFFFFFFFF80000000);
        check("e64_lui_rd", b_id_ex_rd, 5'd5);
        check("e64_lui_legal", b_id_ex_illegal, 1'b0);
        bstep(32'hFE000EE3, 1'b0, 5'd0, 64'd0);
        check("e64_b_imm", b_id_ex_imm, 64'hFFFFFFFFFFFFFFFC);
        bstep(32'h0000007F, 1'b0, 5'd0, 64'd0);
        check("e64_op7f_illegal", b_id_ex_illegal, ILL_ON);
        check("e64_valid", b_id_ex_valid, 1'b1);
        b_if_id_valid = 1'b0; b_wb_we = 1'b0;

        // RV32I instance: directed cases
        step(1'b1, 32'h00028313, 32'h100, 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234);
        check("bypass_rs1", id_ex_rs1_val, 32'h1234);
        step(1'b1, 32'h00000313, 32'h104, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF);
        check("x0_rs1", id_ex_rs1_val, 32'h0);
        step(1'b1, 32'hFFF00293, 32'h108, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        check("addi_imm", id_ex_imm, 32'hFFFFFFFF);
        check("addi_rd", id_ex_rd, 5'd5);
        step(1'b1, 32'hFE000EE3, 32'h10C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        check("beq_imm", id_ex_imm, 32'hFFFFFFFC);

        step(1'b1, 32'h0002A303, 32'h110, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        step(1'b1, 32'h006303B3, 32'h114, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        check("lu_stall_ready", obs_ready, 1'b0);
        check("lu_bubble", id_ex_valid, 1'b0);
        step(1'b1, 32'h006303B3, 32'h114, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        check("lu_issue_ready", obs_ready, 1'b1);
        check("lu_issue_ir", id_ex_ir, 32'h006303B3);
        step(1'b1, 32'h00000337, 32'h118, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        step(1'b1, 32'h006303B3, 32'h11C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        check("lui_no_stall", obs_ready, 1'b1);
        check("lui_add_valid", id_ex_valid, 1'b1);

        step(1'b1, 32'h00A00093, 32'h120, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'h00108113, 32'h124, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
            check("bp_ready", obs_ready, 1'b0);
            check("bp_hold_ir", id_ex_ir, 32'h00A00093);
        end
        step(1'b1, 32'h00108113, 32'h124, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        check("bp_release_ir", id_ex_ir, 32'h00108113);
        step(1'b1, 32'h00110193, 32'h128, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        check("flush_kill", id_ex_valid, 1'b0);
        step(1'b1, 32'h00118213, 32'h12C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        step(1'b1, 32'h00120293, 32'h130, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        check("flush_held_valid", id_ex_valid, 1'b1);
        check("flush_held_ir", id_ex_ir, 32'h00118213);
        step(1'b1, 32'h00120293, 32'h130, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        check("flush_accept", id_ex_valid, 1'b0);

        // Randomized traffic; the bench acts as IF and honours id_ready and flush hand-off
        cur_v = 1'b1; cur_ir = rand_ir(); cur_pc = $urandom; cur_fl = 1'b0;
        for (int i = 0; i < 500; i++) begin
            er = ($urandom_range(0, 3) != 0);
            we = 1'($urandom);
            rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wd = $urandom;
            step(cur_v, cur_ir, cur_pc, er, cur_fl, we, rd, wd);
            if (exp_ready || !cur_v) begin
                cur_v  = ($urandom_range(0, 4) != 0);
                cur_ir = rand_ir();
                cur_pc = $urandom;
            end
            if (!cur_fl || exp_adv) cur_fl = ($urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
